// File: rtl/mdu_iter_pkg.sv
// Shared funct-field codes and multiply/divide unit definitions.
// Imported by the execute-stage multiply/divide unit and its step datapath.
package mdu_iter_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int MDU_ITERS = 32;

    typedef enum logic [1:0] {
        MDU_STATE_IDLE = 2'd0,
        MDU_STATE_CALC = 2'd1,
        MDU_STATE_FIX  = 2'd2
    } mdu_state_t;

    function automatic logic is_arith(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

    function automatic logic is_mdu(input logic [5:0] funct);
        return is_arith(funct) ||
               (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO) ||
               (funct == FUNCT_MTHI) || (funct == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// acc_hi holds the running upper product / remainder, acc_lo the multiplier / quotient.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        addend  = acc_lo[0] ? operand : '0;
        sum     = {1'b0, acc_hi} + {1'b0, addend};
        // Remainder needs one extra bit while the next dividend bit is shifted in.
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        next_hi = '0;
        next_lo = '0;
        if (is_div) begin
            if (diff[WIDTH]) begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                next_hi = diff[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 33 cycles per arithmetic op.
// Operates on magnitudes and restores signs in a final FIX cycle.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             op_valid_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] param_1_i,
    input  logic [WIDTH-1:0] param_2_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(MDU_ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITERS - 1);

    mdu_state_t state, next_state;

    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               is_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;

    logic               start;
    logic               fix_write;
    logic               move_hi;
    logic               move_lo;
    logic               start_div;
    logic               start_signed;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] product_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic             signed_op);
        logic signed [WIDTH-1:0] sval;
        sval = value;
        return (signed_op && sval < 0) ? -value : value;
    endfunction

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .operand (operand),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= MDU_STATE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        fix_write  = 1'b0;
        move_hi    = 1'b0;
        move_lo    = 1'b0;
        case (state)
            MDU_STATE_IDLE: begin
                if (op_valid_i && is_arith(funct_i) && !abort_i) begin
                    start      = 1'b1;
                    next_state = MDU_STATE_CALC;
                end
                move_hi = op_valid_i && (funct_i == FUNCT_MTHI);
                move_lo = op_valid_i && (funct_i == FUNCT_MTLO);
            end
            MDU_STATE_CALC: begin
                if (abort_i) begin
                    next_state = MDU_STATE_IDLE;
                end else if (count == '0) begin
                    next_state = MDU_STATE_FIX;
                end
            end
            MDU_STATE_FIX: begin
                next_state = MDU_STATE_IDLE;
                fix_write  = !abort_i;
            end
            default: next_state = MDU_STATE_IDLE;
        endcase
    end

    // funct bit 1 selects divide, bit 0 selects the unsigned variant.
    assign start_div    = funct_i[1];
    assign start_signed = !funct_i[0];

    // A zero divisor leaves the all-ones quotient unsigned; the remainder sign rule
    // then hands back the original dividend.
    always_comb begin
        product_fixed = {acc_hi, acc_lo};
        if (is_signed && (sign_a ^ sign_b)) begin
            product_fixed = -{acc_hi, acc_lo};
        end
        quot_fixed = acc_lo;
        if (is_signed && (sign_a ^ sign_b) && (operand != '0)) begin
            quot_fixed = -acc_lo;
        end
        rem_fixed = acc_hi;
        if (is_signed && sign_a) begin
            rem_fixed = -acc_hi;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count     <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            operand   <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            if (start) begin
                count     <= CNT_LAST;
                is_div    <= start_div;
                is_signed <= start_signed;
                sign_a    <= param_1_i[WIDTH-1];
                sign_b    <= param_2_i[WIDTH-1];
                acc_hi    <= '0;
                if (start_div) begin
                    operand <= magnitude(param_2_i, start_signed);
                    acc_lo  <= magnitude(param_1_i, start_signed);
                end else begin
                    operand <= magnitude(param_1_i, start_signed);
                    acc_lo  <= magnitude(param_2_i, start_signed);
                end
            end else if (state == MDU_STATE_CALC) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count - 1'b1;
            end
            done <= fix_write;
            if (fix_write) begin
                if (is_div) begin
                    hi <= rem_fixed;
                    lo <= quot_fixed;
                end else begin
                    hi <= product_fixed[2*WIDTH-1:WIDTH];
                    lo <= product_fixed[WIDTH-1:0];
                end
            end else begin
                if (move_hi) hi <= param_1_i;
                if (move_lo) lo <= param_1_i;
            end
        end
    end

    assign hi_o    = hi;
    assign lo_o    = lo;
    assign done_o  = done;
    assign busy_o  = (state != MDU_STATE_IDLE);
    assign stall_o = op_valid_i && busy_o && is_mdu(funct_i);

    always_comb begin
        result_o = '0;
        if (op_valid_i && funct_i == FUNCT_MFHI) result_o = hi;
        else if (op_valid_i && funct_i == FUNCT_MFLO) result_o = lo;
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic results, latency, stall, moves, abort, reset.
module tb_mdu_iter;

    logic        clock_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        op_valid_i = 1'b0;
    logic [5:0]  funct_i = 6'h00;
    logic [31:0] param_1_i = 32'h0;
    logic [31:0] param_2_i = 32'h0;
    logic        abort_i = 1'b0;
    logic [31:0] result_o, hi_o, lo_o;
    logic        busy_o, stall_o, done_o;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    localparam logic [5:0]  DV_F [6] = '{F_DIV, F_DIVU, F_DIVU, F_DIV, F_DIV, F_DIV};
    localparam logic [31:0] DV_A [6] = '{32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000, 32'hFFFFFFF9, 32'd7};
    localparam logic [31:0] DV_B [6] = '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE};
    localparam logic [31:0] DV_H [6] = '{32'hFFFFFFFF, 32'd2, 32'd5, 32'd0, 32'hFFFFFFF9, 32'd1};
    localparam logic [31:0] DV_L [6] = '{32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD};

    mdu_iter #(.WIDTH(32)) dut (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .op_valid_i (op_valid_i),
        .funct_i    (funct_i),
        .param_1_i  (param_1_i),
        .param_2_i  (param_2_i),
        .abort_i    (abort_i),
        .result_o   (result_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .busy_o     (busy_o),
        .stall_o    (stall_o),
        .done_o     (done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    // Presents one op for a single edge, then counts edges until done_o (bounded).
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        op_valid_i = 1'b1; funct_i = f; param_1_i = a; param_2_i = b;
        tick();
        op_valid_i = 1'b0; funct_i = 6'h00; param_1_i = 32'h0; param_2_i = 32'h0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (done_o) break;
        end
    endtask

    task automatic test_reset;
        reset_n_i = 1'b0;
        repeat (3) @(posedge clock_i);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi_o); end
        checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
        @(negedge clock_i);
        reset_n_i = 1'b1;
        tick();
    endtask

    task automatic test_mult;
        int lat;
        run_op(F_MULT, 32'hFFFFFFFE, 32'h3, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        checks++; if (hi_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi_o); end
        checks++; if (lo_o !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", lo_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mult_busy_end: got %b want 0", busy_o); end
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", done_o); end
        run_op(F_MULTU, 32'hFFFFFFFE, 32'h3, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
        checks++; if (hi_o !== 32'h2) begin errors++; $display("FAIL multu_hi: got %h want 00000002", hi_o); end
        checks++; if (lo_o !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo: got %h want fffffffa", lo_o); end
        tick();
    endtask

    task automatic test_div;
        int lat;
        for (int k = 0; k < 6; k++) begin
            run_op(DV_F[k], DV_A[k], DV_B[k], lat);
            checks++; if (lat != 33) begin errors++; $display("FAIL div%0d_latency: got %0d want 33", k, lat); end
            checks++; if (hi_o !== DV_H[k]) begin errors++; $display("FAIL div%0d_hi: got %h want %h", k, hi_o, DV_H[k]); end
            checks++; if (lo_o !== DV_L[k]) begin errors++; $display("FAIL div%0d_lo: got %h want %h", k, lo_o, DV_L[k]); end
            tick();
        end
    endtask

    task automatic test_stall;
        int  edge_n;
        logic stall_bad;
        op_valid_i = 1'b1; funct_i = F_MULT; param_1_i = 32'd3; param_2_i = 32'd5;
        tick();
        op_valid_i = 1'b0;
        repeat (4) tick();
        op_valid_i = 1'b1; funct_i = F_MULT; param_1_i = 32'd7; param_2_i = 32'd7;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL stall_mult_busy: got %b want 1", stall_o); end
        tick();
        op_valid_i = 1'b0; funct_i = 6'h00; param_1_i = 32'h0; param_2_i = 32'h0;
        repeat (4) tick();
        op_valid_i = 1'b1; funct_i = F_MFLO;
        edge_n = 9;
        stall_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            edge_n++;
            if (!busy_o) break;
            if (stall_o !== 1'b1) stall_bad = 1'b1;
        end
        checks++; if (stall_bad !== 1'b0) begin errors++; $display("FAIL stall_mflo_held: got %b want 0", stall_bad); end
        checks++; if (edge_n != 33) begin errors++; $display("FAIL stall_busy_fall: got E%0d want E33", edge_n); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", stall_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done_o); end
        checks++; if (result_o !== 32'd15) begin errors++; $display("FAIL stall_mflo_result: got %h want 0000000f", result_o); end
        op_valid_i = 1'b0; funct_i = 6'h00;
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stall_not_latched: got %b want 0", busy_o); end
        checks++; if (lo_o !== 32'd15) begin errors++; $display("FAIL stall_lo_final: got %h want 0000000f", lo_o); end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(F_MULT, 32'd2, 32'd3, lat);
        checks++; if (lo_o !== 32'd6) begin errors++; $display("FAIL b2b_first_lo: got %h want 00000006", lo_o); end
        op_valid_i = 1'b1; funct_i = F_DIVU; param_1_i = 32'd100; param_2_i = 32'd7;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", stall_o); end
        tick();
        op_valid_i = 1'b0; funct_i = 6'h00;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", busy_o); end
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (done_o) break;
        end
        checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        checks++; if ({hi_o, lo_o} !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_result: got %h_%h want 00000002_0000000e", hi_o, lo_o); end
        tick();
    endtask

    task automatic test_move;
        op_valid_i = 1'b1; funct_i = F_MTHI; param_1_i = 32'h1234;
        tick();
        checks++; if (hi_o !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h want 00001234", hi_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mthi_done: got %b want 0", done_o); end
        funct_i = F_MTLO; param_1_i = 32'hABCD;
        tick();
        checks++; if ({hi_o, lo_o} !== {32'h1234, 32'hABCD}) begin errors++; $display("FAIL mtlo_hilo: got %h_%h want 00001234_0000abcd", hi_o, lo_o); end
        funct_i = F_MFHI; param_1_i = 32'h0;
        #1;
        checks++; if (result_o !== 32'h1234) begin errors++; $display("FAIL mfhi_result: got %h want 00001234", result_o); end
        funct_i = F_MFLO;
        #1;
        checks++; if (result_o !== 32'hABCD) begin errors++; $display("FAIL mflo_result: got %h want 0000abcd", result_o); end
        funct_i = 6'h20;
        #1;
        checks++; if ({stall_o, result_o} !== 33'h0) begin errors++; $display("FAIL other_funct: got %b/%h want 0/0", stall_o, result_o); end
        op_valid_i = 1'b0; funct_i = 6'h00;
        tick();
    endtask

    task automatic test_abort;
        logic saw_done;
        op_valid_i = 1'b1; funct_i = F_DIV; param_1_i = 32'd100; param_2_i = 32'd7;
        tick();
        op_valid_i = 1'b0; funct_i = 6'h00;
        repeat (20) tick();
        abort_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy_e20: got %b want 1", busy_o); end
        tick();
        abort_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_idle_e21: got %b want 0", busy_o); end
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_o) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
        checks++; if ({hi_o, lo_o} !== {32'h1234, 32'hABCD}) begin errors++; $display("FAIL abort_hilo: got %h_%h want 00001234_0000abcd", hi_o, lo_o); end
        op_valid_i = 1'b1; funct_i = F_MULT; param_1_i = 32'd2; param_2_i = 32'd3; abort_i = 1'b1;
        tick();
        op_valid_i = 1'b0; funct_i = 6'h00; abort_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_blocks_start: got %b want 0", busy_o); end
    endtask

    task automatic test_async_reset;
        int lat;
        op_valid_i = 1'b1; funct_i = F_MULT; param_1_i = 32'd6; param_2_i = 32'd7;
        tick();
        op_valid_i = 1'b0; funct_i = 6'h00;
        repeat (10) tick();
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy_o); end
        checks++; if ({hi_o, lo_o} !== 64'h0) begin errors++; $display("FAIL areset_hilo: got %h_%h want 0_0", hi_o, lo_o); end
        @(posedge clock_i);
        @(negedge clock_i);
        reset_n_i = 1'b1;
        tick();
        run_op(F_MULT, 32'd6, 32'd7, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL areset_mult_latency: got %0d want 33", lat); end
        checks++; if ({hi_o, lo_o} !== {32'h0, 32'd42}) begin errors++; $display("FAIL areset_mult_result: got %h_%h want 00000000_0000002a", hi_o, lo_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_back_to_back();
        test_move();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit in the execute stage, alongside the ALU. It takes the same operand pair from the ID/EX register and computes MULT/MULTU/DIV/DIVU over 33 cycles instead of one. It owns the architectural HI/LO registers, serves MFHI/MFLO/MTHI/MTLO, and raises a stall to the pipeline control while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32, operand width (matches GPR width); HI and LO are each `WIDTH` bits.

Ports:
- `clock_i`  in  1  clock; all state updates on the operate edge.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `op_valid_i`  in  1  the ID/EX register holds a valid instruction this cycle.
- `funct_i`  in  6  funct field, using the shared funct-field codes.
- `param_1_i`  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- `param_2_i`  in  WIDTH  rt operand (divisor / multiplier).
- `abort_i`  in  1  exception flush; discards any in-flight operation.
- `result_o`  out  WIDTH  HI for MFHI, LO for MFLO, 0 otherwise; combinational.
- `hi_o`, `lo_o`  out  WIDTH  current HI/LO.
- `busy_o`  out  1  state is not IDLE.
- `stall_o`  out  1  combinational: `op_valid_i` and busy_o and funct is any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- `done_o`  out  1  one-cycle pulse after HI/LO are written by an arithmetic op.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + `op_valid_i` + arithmetic funct: latch |operands| (signed ops) or raw operands (unsigned ops), op kind, and both sign bits; count := 31; go to CALC.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract (remainder WIDTH+1 bits).
  - At count 0, go to FIX; otherwise decrement.
- FIX: apply signs, then write HI/LO and go to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Writes: multiply gives HI=product[63:32], LO=product[31:0]; divide gives LO=quotient, HI=remainder.
- MTHI/MTLO in IDLE with `op_valid_i`: write HI/LO from `param_1_i` on the next edge. This is a single-cycle operation and does not pulse done_o.
- Request while busy: stall_o=1, the request is not latched, and the pipeline re-presents it.
- Divide by zero, unsigned: LO=0xFFFFFFFF, HI=param_1.
- Divide by zero, signed: LO=0xFFFFFFFF, HI=param_1 (the sign fix is skipped).
- 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
- abort_i while in CALC or FIX: return to IDLE on the next edge, HI/LO unchanged, no done_o. abort_i in IDLE has no effect; it also blocks a start presented in the same cycle.
- Other functs: ignored.

## Timing
- Reset values: all state and outputs zero, state IDLE; hi_o=lo_o=0, busy_o=0, done_o=0.
- Start accepted at edge E0. CALC covers edges E1..E32, FIX completes at E33.
- HI/LO are visible from E33, and done_o is high for the cycle after E33. busy_o is high from E0 to E33.
- Back-to-back: a new start is accepted at the first edge where busy_o is low, i.e. E33 or later. The same cycle as done_o is legal.
- MFHI issued in the done_o cycle returns the new HI.
- Reset asserted mid-operation clears everything immediately; no HI/LO write occurs.

## Structure
- Funct codes come from the shared funct-field definitions. Add `MDU_STATE_*` constants and the cycle count (`MDU_ITERS`=32) to the shared defines.
- One sub-module, `mdu_step`: combinational single radix-2 step for both multiply and divide, selected by op kind.
- `mdu_iter` holds the FSM, the counter, the sign fix-up, and HI/LO.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFFA, done_o pulses once. The same operands under MULTU → HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2.
- DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MFLO presented at E10 of a MULT → stall_o=1 until busy_o falls; the MFLO issued in the done_o cycle returns the new LO. A second MULT issued at E5 is not latched.
- MTHI 0x1234 in IDLE → hi_o=0x1234 the next cycle, done_o stays 0. abort_i at E20 of a DIV → IDLE at E21, HI/LO unchanged, no done_o.
- reset_n_i pulsed low mid-CALC → busy_o=0 and hi_o=lo_o=0 asynchronously. The first MULT after release completes normally.
